// File: rtl/m_udp_tx_loader.sv
// m_udp_tx_loader
//   Writer side of the UDP transmit path. It packs the user payload byte stream
//   big-endian into 32-bit words in the transmit payload RAM and computes the UDP
//   and IP length fields. It then requests one frame from the IP/UDP transmitter
//   and waits until the transmitter reports completion.
//
//   Ports
//     clk, reset_n                   transmit clock, async active-low reset
//     s_data/s_valid/s_last/s_ready  payload byte stream in
//     ram_wr_en/addr/data            payload RAM write port (first byte in [31:23+1])
//     tx_data_length                 UDP length  = payload bytes + 8
//     tx_total_length                IP length   = payload bytes + 28
//     tx_req / tx_done               frame request, held until completion pulse
//     overflow                       current/last frame exceeded MAX_BYTES
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | first cycle after reset release, s_ready still low
//   ST_FILL | accepting payload bytes, packing words into RAM
//   ST_LEN  | one cycle: latch length fields, final RAM write in flight
//   ST_REQ  | tx_req high, waiting for tx_done
module m_udp_tx_loader #(
    parameter int ADDR_W    = 9,
    parameter int BASE_ADDR = 0,
    parameter int MAX_BYTES = 1472
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [31:0]       ram_wr_data,
    output logic [15:0]       tx_data_length,
    output logic [15:0]       tx_total_length,
    output logic              tx_req,
    input  logic              tx_done,
    output logic              overflow
);

    typedef enum logic [1:0] {ST_INIT, ST_FILL, ST_LEN, ST_REQ} state_t;

    localparam logic [15:0]       MAX_CNT = 16'(MAX_BYTES);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

    state_t            state, state_nxt;
    logic [15:0]       byte_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       word_acc;
    logic [31:0]       word_nxt;
    logic [1:0]        lane;
    logic              accept;
    logic              at_max;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_INIT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        tx_req    = 1'b0;
        case (state)
            ST_INIT: state_nxt = ST_FILL;
            ST_FILL: begin
                s_ready = 1'b1;
                if (s_valid && s_last) state_nxt = ST_LEN;
            end
            ST_LEN:  state_nxt = ST_REQ;
            ST_REQ: begin
                tx_req = 1'b1;
                if (tx_done) state_nxt = ST_FILL;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    assign accept = s_valid && s_ready;
    assign lane   = byte_cnt[1:0];
    assign at_max = (byte_cnt == MAX_CNT);

    // Accumulated word with the incoming byte dropped into its lane.
    always_comb begin
        word_nxt = word_acc;
        case (lane)
            2'd0:    word_nxt[31:24] = s_data;
            2'd1:    word_nxt[23:16] = s_data;
            2'd2:    word_nxt[15:8]  = s_data;
            default: word_nxt[7:0]   = s_data;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt        <= '0;
            word_idx        <= '0;
            word_acc        <= '0;
            ram_wr_en       <= 1'b0;
            ram_wr_addr     <= BASE;
            ram_wr_data     <= '0;
            tx_data_length  <= '0;
            tx_total_length <= '0;
            overflow        <= 1'b0;
        end else begin
            ram_wr_en <= 1'b0;
            if (accept) begin
                if (byte_cnt == 16'd0) overflow <= 1'b0;
                if (!at_max) begin
                    byte_cnt <= byte_cnt + 16'd1;
                    if (lane == 2'd3 || s_last) begin
                        ram_wr_en   <= 1'b1;
                        ram_wr_addr <= BASE + word_idx;
                        ram_wr_data <= word_nxt;
                        word_idx    <= word_idx + 1'b1;
                        word_acc    <= '0;
                    end else begin
                        word_acc <= word_nxt;
                    end
                end else begin
                    // Saturated: byte is consumed and dropped. A partial word
                    // (only possible for MAX_BYTES not a multiple of 4) is still
                    // flushed when the frame ends.
                    overflow <= 1'b1;
                    if (s_last && lane != 2'd0) begin
                        ram_wr_en   <= 1'b1;
                        ram_wr_addr <= BASE + word_idx;
                        ram_wr_data <= word_acc;
                        word_idx    <= word_idx + 1'b1;
                        word_acc    <= '0;
                    end
                end
            end
            if (state == ST_LEN) begin
                tx_data_length  <= byte_cnt + 16'd8;
                tx_total_length <= byte_cnt + 16'd28;
            end
            if (state == ST_REQ && tx_done) begin
                byte_cnt <= '0;
                word_idx <= '0;
                word_acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_m_udp_tx_loader.sv
// Testbench for m_udp_tx_loader: directed and randomized frames checked
// against a payload-level reference model (expected RAM image and lengths).
module tb_m_udp_tx_loader;

    localparam int ADDR_W    = 9;
    localparam int BASE_ADDR = 0;
    localparam int MAX_BYTES = 1472;

    logic              clk;
    logic              reset_n;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [31:0]       ram_wr_data;
    logic [15:0]       tx_data_length;
    logic [15:0]       tx_total_length;
    logic              tx_req;
    logic              tx_done;
    logic              overflow;

    int checks;
    int failures;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t        act_q[$];
    logic [7:0] pay[$];

    m_udp_tx_loader #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR),
        .MAX_BYTES(MAX_BYTES)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_last         (s_last),
        .s_ready        (s_ready),
        .ram_wr_en      (ram_wr_en),
        .ram_wr_addr    (ram_wr_addr),
        .ram_wr_data    (ram_wr_data),
        .tx_data_length (tx_data_length),
        .tx_total_length(tx_total_length),
        .tx_req         (tx_req),
        .tx_done        (tx_done),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every RAM write strobe.
    always @(negedge clk) begin
        if (reset_n && ram_wr_en) act_q.push_back('{ram_wr_addr, ram_wr_data});
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_s_ready"},  32'(s_ready), 32'd0);
        check_val({tag, "_wr_en"},    32'(ram_wr_en), 32'd0);
        check_val({tag, "_wr_addr"},  32'(ram_wr_addr), 32'(BASE_ADDR));
        check_val({tag, "_wr_data"},  ram_wr_data, 32'd0);
        check_val({tag, "_data_len"}, 32'(tx_data_length), 32'd0);
        check_val({tag, "_tot_len"},  32'(tx_total_length), 32'd0);
        check_val({tag, "_tx_req"},   32'(tx_req), 32'd0);
        check_val({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_val({tag, "_ready_first"}, 32'(s_ready), 32'd0);
        @(negedge clk);
        check_val({tag, "_ready_after"}, 32'(s_ready), 32'd1);
    endtask

    // Sends the bytes in pay[] as one frame and completes the request handshake.
    task automatic run_frame(input string tag, input bit hold);
        wr_t         exp_q[$];
        int          n;
        int          stored;
        int          i;
        int          guard;
        int          nwr;
        logic [31:0] w;
        bit          exp_strobe;

        act_q.delete();
        n      = pay.size();
        stored = (n > MAX_BYTES) ? MAX_BYTES : n;
        for (int k = 0; k < (stored + 3) / 4; k++) begin
            w = '0;
            for (int b = 0; b < 4; b++)
                if (4 * k + b < stored) w[31 - 8 * b -: 8] = pay[4 * k + b];
            exp_q.push_back('{ADDR_W'(BASE_ADDR + k), w});
        end
        exp_strobe = (n <= MAX_BYTES) || (stored % 4 != 0);

        i = 0;
        guard = 0;
        while (i < n && guard < 20000) begin
            @(negedge clk);
            guard++;
            tx_done = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                s_last  = 1'($urandom_range(0, 1));
                s_data  = 8'($urandom);
            end else begin
                s_valid = 1'b1;
                s_data  = pay[i];
                s_last  = (i == n - 1);
                if (s_ready) i++;
            end
        end
        check_val({tag, "_accept_all"}, 32'(i), 32'(n));

        @(negedge clk);
        tx_done = 1'b0;
        s_valid = hold;
        s_last  = 1'b0;
        s_data  = 8'hA5;
        check_val({tag, "_strobe_t1"}, 32'(ram_wr_en), 32'(exp_strobe));
        check_val({tag, "_req_low_t1"}, 32'(tx_req), 32'd0);

        @(negedge clk);
        check_val({tag, "_req_t2"},   32'(tx_req), 32'd1);
        check_val({tag, "_data_len"}, 32'(tx_data_length), 32'(stored + 8));
        check_val({tag, "_tot_len"},  32'(tx_total_length), 32'(stored + 28));
        check_val({tag, "_overflow"}, 32'(overflow), 32'(n > MAX_BYTES));
        check_val({tag, "_num_wr"},   32'(act_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            if (act_q[k].a !== exp_q[k].a) check_val({tag, "_wr_addr"}, 32'(act_q[k].a), 32'(exp_q[k].a));
            if (act_q[k].d !== exp_q[k].d) check_val({tag, "_wr_data"}, act_q[k].d, exp_q[k].d);
        end
        if (exp_q.size() > 0) begin
            check_val({tag, "_last_addr"}, 32'(act_q[$].a), 32'(exp_q[$].a));
            check_val({tag, "_last_data"}, act_q[$].d, exp_q[$].d);
        end

        nwr = act_q.size();
        repeat ($urandom_range(1, 4)) begin
            @(negedge clk);
            check_val({tag, "_req_hold"},   32'(tx_req), 32'd1);
            check_val({tag, "_ready_req"},  32'(s_ready), 32'd0);
        end
        check_val({tag, "_no_wr_req"}, 32'(act_q.size()), 32'(nwr));

        tx_done = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        tx_done = 1'b0;
        check_val({tag, "_req_drop"},  32'(tx_req), 32'd0);
        check_val({tag, "_ready_back"}, 32'(s_ready), 32'd1);
        check_val({tag, "_len_keep"},  32'(tx_data_length), 32'(stored + 8));
    endtask

    initial begin
        int k;
        int guard;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        s_data   = '0;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        tx_done  = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        release_reset("por");

        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_frame("four", 1'b0);

        pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_frame("five", 1'b1);

        pay.delete();
        for (int j = 0; j < 1480; j++) pay.push_back(8'($urandom));
        run_frame("big", 1'b0);

        pay = '{8'($urandom)};
        run_frame("one", 1'b0);

        // Abandon a frame mid-way with reset.
        k = 0;
        guard = 0;
        while (k < 6 && guard < 200) begin
            @(negedge clk);
            guard++;
            s_valid = 1'b1;
            s_data  = 8'($urandom);
            s_last  = 1'b0;
            if (s_ready) k++;
        end
        check_val("mid_accept", 32'(k), 32'd6);
        @(negedge clk);
        s_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        release_reset("mid_rst");

        pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame("after_rst", 1'b0);

        for (int f = 0; f < 12; f++) begin
            pay.delete();
            for (int j = 0; j < $urandom_range(1, 40); j++) pay.push_back(8'($urandom));
            run_frame($sformatf("rnd%0d", f), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
